uart_tx_fifo: RTL

Byte FIFO and drain sequencer upstream of the UART transmitter. The CPU-side bus writes bytes at any rate up to one per clock. The block buffers them and issues each byte to the transmitter as a single-cycle write strobe, only while the transmitter reports not busy. It decouples software stores from the ~87 us per-byte serial time at 115.2 kbps.

---
 rtl/uart_tx_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: buffers CPU writes and issues each
// byte as a one-cycle strobe once the transmitter reports idle.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_busy
);

  localparam int DATA_W = 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                push;
  logic                pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Occupancy bookkeeping; a write while full is dropped even if a pop lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ISSUE absorbs the transmitter's one-cycle lag in raising busy before WAIT trusts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_we   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_we   <= 1'b1;
            state   <= ISSUE;
          end else begin
            tx_we   <= 1'b0;
          end
        end
        ISSUE: begin
          tx_we <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          tx_we <= 1'b0;
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          tx_we <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
